// File: rtl/fir_result_fifo.sv
// Output conditioning for the decimation FIR: round, scale and saturate each sample,
// then buffer the codes in a small FIFO that the consumer drains with valid/ready.
module fir_result_fifo #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 8,
    parameter int SHIFT = 0,
    parameter int OUT_W = 24,
    parameter int DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic signed [WIDTH+FRAC-1:0]    fir_in,
    input  logic                            fir_valid,
    input  logic                            clr_ovf,
    output logic signed [OUT_W-1:0]         dout,
    output logic                            dout_sat,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            overflow,
    output logic [15:0]                     drop_count
);

    localparam int IN_W  = WIDTH + FRAC;
    localparam int EXT_W = IN_W + 1;
    localparam int S     = FRAC + SHIFT;
    localparam int AW    = $clog2(DEPTH);

    localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [AW:0]             FULL_CNT = (AW+1)'(DEPTH);

    // One extra bit of headroom so adding the rounding constant cannot wrap.
    logic signed [EXT_W-1:0] ext_v;
    logic signed [EXT_W-1:0] rnd_v;

    assign ext_v = {fir_in[IN_W-1], fir_in};

    generate
        if (S > 0) begin : g_round
            localparam logic signed [EXT_W-1:0] HALF = {{(EXT_W-1){1'b0}}, 1'b1} << (S-1);
            assign rnd_v = (ext_v + HALF) >>> S;
        end else begin : g_pass
            assign rnd_v = ext_v;
        end
    endgenerate

    logic [OUT_W-1:0] cond_code_d, cond_code_q;
    logic             cond_sat_d,  cond_sat_q;
    logic             cond_valid_q;

    always_comb begin
        cond_code_d = rnd_v[OUT_W-1:0];
        cond_sat_d  = 1'b0;
        if (rnd_v > MAX_V) begin
            cond_code_d = MAX_V[OUT_W-1:0];
            cond_sat_d  = 1'b1;
        end else if (rnd_v < MIN_V) begin
            cond_code_d = MIN_V[OUT_W-1:0];
            cond_sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cond_valid_q <= 1'b0;
            cond_code_q  <= '0;
            cond_sat_q   <= 1'b0;
        end else begin
            cond_valid_q <= fir_valid;
            cond_code_q  <= cond_code_d;
            cond_sat_q   <= cond_sat_d;
        end
    end

    logic [OUT_W:0] mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, rd_ptr_q;
    logic [OUT_W:0] head;
    logic           full, rd_en, wr_en, drop;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign full       = (count == FULL_CNT);
    assign dout_valid = (count != '0);
    assign rd_en      = dout_valid & dout_ready;
    assign wr_en      = cond_valid_q & (~full | rd_en);
    assign drop       = cond_valid_q & full & ~rd_en;

    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign dout     = dout_valid ? head[OUT_W-1:0] : '0;
    assign dout_sat = dout_valid ? head[OUT_W] : 1'b0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cond_sat_q, cond_code_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    logic        overflow_d, overflow_q;
    logic [15:0] drop_count_d, drop_count_q;

    // A drop in the same cycle as a clear wins: the clear is applied first.
    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_count_d = 16'd1;
            end else if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end else if (clr_ovf) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fir_result_fifo.sv
// Randomized and directed bench for fir_result_fifo with a queue-based scoreboard
// fed by an arithmetic reference model and drained by an independent monitor.
module tb_fir_result_fifo;

    localparam int WIDTH = 32;
    localparam int FRAC  = 8;
    localparam int SHIFT = 0;
    localparam int OUT_W = 24;
    localparam int DEPTH = 8;
    localparam int IN_W  = WIDTH + FRAC;

    typedef struct {
        longint code;
        bit     sat;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [IN_W-1:0]   fir_in;
    logic              fir_valid;
    logic              clr_ovf;
    logic [OUT_W-1:0]  dout;
    logic              dout_sat;
    logic              dout_valid;
    logic              dout_ready;
    logic [$clog2(DEPTH):0] count;
    logic              overflow;
    logic [15:0]       drop_count;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];
    bit     pend_v    = 1'b0;
    exp_t   pend_e;
    int     m_count   = 0;
    bit     m_ovf     = 1'b0;
    int     m_drops   = 0;

    fir_result_fifo #(
        .WIDTH(WIDTH), .FRAC(FRAC), .SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .fir_in(fir_in), .fir_valid(fir_valid),
        .clr_ovf(clr_ovf), .dout(dout), .dout_sat(dout_sat), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .count(count), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference conditioning: real-valued round-half-up then clamp to the code range.
    function automatic exp_t condition(input logic [IN_W-1:0] x);
        exp_t   e;
        longint v;
        longint r;
        longint hi;
        longint lo;
        v  = longint'($signed(x));
        r  = longint'($floor(real'(v) / (2.0 ** (FRAC + SHIFT)) + 0.5));
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        e.sat  = (r > hi) || (r < lo);
        e.code = (r > hi) ? hi : ((r < lo) ? lo : r);
        return e;
    endfunction

    // Occupancy-level model of the buffer; accepted samples go to the scoreboard.
    always @(posedge clk) begin
        bit rd, wr, dr;
        if (reset) begin
            pend_v  = 1'b0;
            m_count = 0;
            exp_q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            rd = (m_count > 0) && dout_ready;
            wr = pend_v && ((m_count < DEPTH) || rd);
            dr = pend_v && !wr;
            if (wr) exp_q.push_back(pend_e);
            m_count = m_count - int'(rd) + int'(wr);
            if (dr) begin
                m_ovf   = 1'b1;
                m_drops = clr_ovf ? 1 : ((m_drops < 65535) ? m_drops + 1 : 65535);
            end else if (clr_ovf) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
            pend_v = fir_valid;
            if (fir_valid) pend_e = condition(fir_in);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        chk("count", count, m_count);
        chk("dout_valid", dout_valid, m_count != 0);
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drops);
        if (!dout_valid) begin
            chk("empty_dout", {dout_sat, dout}, 0);
        end else if (dout_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_dout", $signed(dout), e.code);
                chk("sb_sat", dout_sat, e.sat);
                $display("read dout=%0d sat=%0d", $signed(dout), dout_sat);
            end
        end
    end

    // Inputs change 2 time units after an edge and are sampled at the following edge.
    task automatic cyc(input bit v, input logic [IN_W-1:0] d, input bit rdy,
                       input bit clr = 1'b0, input bit rst = 1'b0);
        @(posedge clk);
        #2;
        fir_valid  = v;
        fir_in     = d;
        dout_ready = rdy;
        clr_ovf    = clr;
        reset      = rst;
    endtask

    function automatic logic [IN_W-1:0] sc(input longint v);
        return IN_W'(v * 256);
    endfunction

    logic [IN_W-1:0] rvals [3];
    longint          rexp  [3];

    initial begin
        logic [63:0]     t;
        logic [IN_W-1:0] d;
        reset = 1'b1; fir_in = '0; fir_valid = 1'b0; clr_ovf = 1'b0; dout_ready = 1'b0;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_dout", $signed(dout), 0);
        chk("rst_ovf", overflow, 0);

        // Rounding, with latency of two edges from fir_valid to dout_valid.
        rvals[0] = IN_W'(640);  rexp[0] = 3;
        rvals[1] = IN_W'(-640); rexp[1] = -2;
        rvals[2] = IN_W'(383);  rexp[2] = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(1, rvals[i], 1);
            cyc(0, 0, 1);
            chk("lat_edge1", dout_valid, 0);
            cyc(0, 0, 1);
            chk("lat_edge2", dout_valid, 1);
            chk("round_dout", $signed(dout), rexp[i]);
            chk("round_sat", dout_sat, 0);
        end
        repeat (3) cyc(0, 0, 1);

        // Saturation boundaries.
        rvals[0] = IN_W'((longint'(1) << 38) - 1); rexp[0] = 8388607;
        rvals[1] = IN_W'(-(longint'(1) << 38));    rexp[1] = -8388608;
        rvals[2] = sc(8388607);                    rexp[2] = 8388607;
        for (int i = 0; i < 3; i++) begin
            cyc(1, rvals[i], 1);
            cyc(0, 0, 1);
            cyc(0, 0, 1);
            chk("sat_dout", $signed(dout), rexp[i]);
            chk("sat_flag", dout_sat, i < 2);
        end
        repeat (3) cyc(0, 0, 1);

        // Overflow: ten samples into a stalled consumer.
        for (int i = 1; i <= 10; i++) cyc(1, sc(i), 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        chk("ovf_count", count, 8);
        chk("ovf_drops", drop_count, 2);
        chk("ovf_flag", overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", $signed(dout), i);
            cyc(0, 0, 1);
        end
        chk("drain_count", count, 0);

        // Clear alone, then clear coincident with a drop.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_drops", drop_count, 0);
        for (int i = 1; i <= 9; i++) cyc(1, sc(40 + i), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0);
        chk("clrdrop_ovf", overflow, 1);
        chk("clrdrop_drops", drop_count, 1);
        repeat (10) cyc(0, 0, 1);

        // Full with simultaneous read and write, across pointer wrap.
        for (int i = 1; i <= 9; i++) cyc(1, sc(100 + i), 0);
        for (int i = 10; i <= 14; i++) begin
            cyc(1, sc(100 + i), 1);
            chk("full_rw_count", count, 8);
        end
        cyc(0, 0, 1);
        chk("full_rw_count", count, 8);
        cyc(0, 0, 1);
        chk("full_rw_count", count, 8);
        chk("full_rw_drops", drop_count, 1);
        repeat (12) cyc(0, 0, 1);

        // Reset with five entries buffered and a sample presented during reset.
        cyc(0, 0, 0, 1);
        for (int i = 1; i <= 5; i++) cyc(1, sc(200 + i), 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("pre_rst_count", count, 5);
        cyc(1, sc(99), 0, 0, 1);
        cyc(1, sc(7), 1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_dout", $signed(dout), 0);
        chk("mid_rst_ovf", overflow, 0);
        cyc(0, 0, 1);
        chk("post_rst_lat", dout_valid, 0);
        cyc(0, 0, 1);
        chk("post_rst_valid", dout_valid, 1);
        chk("post_rst_dout", $signed(dout), 7);
        repeat (3) cyc(0, 0, 1);

        // Random traffic with bursts of consumer stall.
        for (int n = 0; n < 600; n++) begin
            t = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       d = t[IN_W-1:0];
                1:       d = IN_W'(longint'($signed(t[31:0])));
                2:       d = IN_W'(longint'($signed(t[15:0])));
                default: d = ($urandom_range(0, 1) != 0) ? IN_W'(longint'(8388607) * 256 + 127)
                                                        : IN_W'(-(longint'(8388608) * 256) - 129);
            endcase
            cyc($urandom_range(0, 3) != 0, d, ((n / 40) % 3 == 2) ? 1'b0 : ($urandom_range(0, 2) != 0),
                $urandom_range(0, 40) == 0, $urandom_range(0, 200) == 0);
        end
        repeat (14) cyc(0, 0, 1);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_result_fifo.md
# fir_result_fifo

Output-conditioning and buffering stage placed directly downstream of the 128-tap decimation FIR. Each FIR output is a signed fixed-point word (WIDTH integer bits, FRAC fractional bits) qualified by `fir_valid`. The block rounds and scales each sample, then saturates it to an OUT_W-bit signed integer code. Conditioned codes go into a small FIFO that the consumer (host interface or capture logic) drains with a valid/ready handshake, and overflow events are counted.

## Interface
Parameters:
- `WIDTH`, 32, integer width of the FIR datapath
- `FRAC`, 8, fractional bits of `fir_in`
- `SHIFT`, 0, extra arithmetic right shift (gain 2^-SHIFT), 0..8
- `OUT_W`, 24, output code width, 2..WIDTH
- `DEPTH`, 8, FIFO entries, power of two, ≥2

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `fir_in`  in  WIDTH+FRAC  signed FIR output, two's complement
- `fir_valid`  in  1  `fir_in` is valid this cycle
- `clr_ovf`  in  1  single-cycle pulse; clears `overflow` and `drop_count`
- `dout`  out  OUT_W  signed head-of-FIFO code
- `dout_sat`  out  1  head sample was saturated
- `dout_valid`  out  1  FIFO non-empty
- `dout_ready`  in  1  consumer accepts head this cycle
- `count`  out  log2(DEPTH)+1  FIFO occupancy
- `overflow`  out  1  sticky flag: a sample was dropped
- `drop_count`  out  16  dropped samples, saturates at 0xFFFF

## Operation
- Conditioning stage, registered:
  - Let S = FRAC+SHIFT.
  - If S>0: r = (fir_in + 2^(S-1)) >>> S, computed at WIDTH+FRAC+1 bits so the add cannot wrap. This is round half toward +inf.
  - If S=0: r = fir_in.
  - If r > 2^(OUT_W-1)-1, code = 2^(OUT_W-1)-1 and sat=1. If r < -2^(OUT_W-1), code = -2^(OUT_W-1) and sat=1. Otherwise code = r and sat=0.
  - {code, sat, cond_valid} are registered on each edge. cond_valid follows `fir_valid`.
- FIFO: DEPTH entries of OUT_W+1 bits. Read and write pointers are log2(DEPTH)+1 bits and wrap naturally. `count` = wr−rd.
- Write happens when cond_valid is 1 and (count<DEPTH or a read occurs this cycle).
- Read happens when `dout_valid` && `dout_ready`.
- `dout`/`dout_sat` always show the head entry. When empty they are held at 0.
- Drop: cond_valid=1, count=DEPTH and no read this cycle. The sample is discarded, `overflow` is set to 1, and `drop_count` increments (saturating at 0xFFFF).
- `clr_ovf` together with a drop in the same cycle: the drop wins, giving `overflow`=1 and `drop_count`=1.
- `dout_ready` while empty is ignored, and pointers do not move.
- Reset:
  - Pointers, `count`, cond_valid, `overflow`, `drop_count`, `dout`, `dout_sat` and `dout_valid` all go to 0.
  - Contents buffered at the time of reset are discarded.
  - Any input accepted in the same cycle as reset is ignored.

## Timing
- Latency: `fir_valid`=1 sampled at edge k → conditioned at edge k → written at edge k+1 → `dout_valid`=1 after edge k+1 (when previously empty). There is no combinational bypass.
- Throughput: one sample per clock in and out. Back-to-back `fir_valid` is supported.
- Read at full with a simultaneous write: both happen, and `count` stays at DEPTH.
- Read with no write: `count` decrements and the next head appears after the same edge.
- `dout_valid` depends only on registered state. There is no combinational path from `dout_ready` or `fir_valid` to any output.
- `overflow`/`drop_count` update on the edge at which the drop occurs.

## Test plan
1. **Rounding** (FRAC=8, SHIFT=0, `dout_ready`=1):
   - `fir_in`=640 (2.5) → `dout`=3.
   - `fir_in`=−640 → `dout`=−2.
   - `fir_in`=383 → `dout`=1.
   - All three with `dout_sat`=0. Each `dout_valid` pulse occurs 2 edges after its `fir_valid`.
2. **Saturation**:
   - `fir_in`=2^38−1 → `dout`=8388607, `dout_sat`=1.
   - `fir_in`=−2^38 → `dout`=−8388608, `dout_sat`=1.
   - `fir_in`=8388607·256 → 8388607 with `dout_sat`=0.
3. **Overflow** (`dout_ready`=0): 10 consecutive samples 1..10 (scaled by 256).
   - Result: `count`=8, `drop_count`=2, `overflow`=1.
   - Draining then returns 1..8 in order, and `count` reaches 0.
4. **Full with simultaneous traffic**: at `count`=8, assert `fir_valid` and `dout_ready` together for 5 cycles.
   - `count` stays 8 and `drop_count` is unchanged.
   - Output order is preserved across pointer wrap-around.
5. **Clear**:
   - `clr_ovf` pulse → `overflow`=0, `drop_count`=0.
   - `clr_ovf` coincident with a drop → `overflow`=1, `drop_count`=1.
6. **Reset mid-operation**: with 5 entries buffered, assert `reset` for 1 cycle.
   - Next cycle: `count`=0, `dout_valid`=0, `dout`=0, `overflow`=0.
   - A new sample of 7·256 emerges as `dout`=7 two edges after its `fir_valid`.
